encode_acc_requant: RTL

ENCODE_ACC_REQUANT -- requirements
Module: encode_acc_requant

---
 rtl/encode_acc_pkg.sv | 9 +
 rtl/encode_round_sat.sv | 28 ++
 rtl/encode_acc_requant.sv | 92 +++++++++
 3 files changed

// File: rtl/encode_acc_pkg.sv
// encode_acc_pkg: shared FSM state type and default widths for the accumulate/requantise block
package encode_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_e;
  localparam int DEF_PROD_WIDTH = 62;
  localparam int DEF_ACC_WIDTH = 72;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_SHIFT = 24;
  localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/encode_round_sat.sv
// encode_round_sat: round half toward +inf, arithmetic shift right, then clip to the output range
module encode_round_sat import encode_acc_pkg::*; #(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);
  localparam int RS = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [ACC_WIDTH:0] ONE = 1;
  localparam logic signed [ACC_WIDTH:0] RND_C = (SHIFT == 0) ? '0 : ONE << RS;
  localparam logic signed [ACC_WIDTH:0] MAXV = (ONE << (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [ACC_WIDTH:0] MINV = -(ONE << (OUT_WIDTH - 1));
  logic signed [ACC_WIDTH:0] ext, sum, r;
  logic hi, lo;
  // one extra bit keeps the rounding add from overflowing
  always_comb begin
    ext = {acc_i[ACC_WIDTH-1], acc_i};
    sum = ext + RND_C;
    r = sum >>> SHIFT;
    hi = r > MAXV;
    lo = r < MINV;
    data_o = hi ? MAXV[OUT_WIDTH-1:0] : lo ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    sat_o = hi | lo;
  end
endmodule

// File: rtl/encode_acc_requant.sv
// encode_acc_requant: accumulates len signed products onto a bias, then rounds, shifts and saturates
module encode_acc_requant import encode_acc_pkg::*; #(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT = DEF_SHIFT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [PROD_WIDTH-1:0] bias,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  prod_ready,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  input  logic                  out_ready,
  output logic                  busy
);
  state_e state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d, rs_data;
  logic out_sat_q, out_sat_d, rs_sat;

  encode_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .acc_i(acc_q),
    .data_o(rs_data),
    .sat_o(rs_sat)
  );

  // state and datapath registers advance only when ce is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
    end
  end

  // next state: load on start, add one term per handshake, capture the result in RND
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    out_sat_d = out_sat_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d = ACC_WIDTH'($signed(bias));
        cnt_d = len;
        state_d = (len != '0) ? ACC : RND;
      end
      ACC: if (prod_valid) begin
        acc_d = acc_q + ACC_WIDTH'($signed(prod_data));
        cnt_d = cnt_q - CNT_WIDTH'(1);
        state_d = (cnt_q == CNT_WIDTH'(1)) ? RND : ACC;
      end
      RND: begin
        out_data_d = rs_data;
        out_sat_d = rs_sat;
        state_d = OUT;
      end
      default: state_d = out_ready ? IDLE : OUT;
    endcase
  end

  // outputs are pure functions of the registered state
  always_comb begin
    prod_ready = state_q == ACC;
    out_valid = state_q == OUT;
    busy = state_q != IDLE;
    out_data = out_data_q;
    out_sat = out_sat_q;
  end
endmodule
